pulse_meter: RTL and testbench

//   Receive end of the slow square-wave heartbeat produced by the on-board clock divider.

---
 rtl/pulse_meter_if.sv | 21 ++
 rtl/pulse_meter.sv | 145 ++++++++++++++
 tb/tb_pulse_meter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// Result channel of pulse_meter: the measured period handed to the consumer
// under valid/ready flow control.
interface pulse_meter_if #(
    parameter int CNT_W = 32
);
    logic [CNT_W-1:0] period_o;
    logic             period_valid;
    logic             period_ready;

    modport master (
        output period_o,
        output period_valid,
        input  period_ready
    );

    modport slave (
        input  period_o,
        input  period_valid,
        output period_ready
    );
endinterface

// File: rtl/pulse_meter.sv
// Heartbeat receiver: synchronises pulse_in, measures rise-to-rise period and flags stalls.
// Define PULSE_METER_AVG_EN to report a sliding mean of the last 4 periods instead of the raw one.
module pulse_meter #(
    parameter int CLK_HZ      = 27_000_000,
    parameter int MAX_PERIOD  = CLK_HZ / 5,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    output logic          pulse_lvl,
    pulse_meter_if.master result,
    output logic          timeout,
    output logic          overrun
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       counter;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_d;
    logic                   rise;
    logic                   capture;
    logic                   stall;
    logic                   new_result;
    logic [CNT_W-1:0]       result_val;

    assign pulse_lvl = sync_q[SYNC_STAGES-1];
    assign rise      = pulse_lvl & ~synced_d;
    assign capture   = rise && (state == MEASURE);
    assign stall     = (state == MEASURE) && !rise && (counter == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            synced_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            synced_d <= sync_q[SYNC_STAGES-1];
        end
    end

`ifdef PULSE_METER_AVG_EN
    logic [CNT_W+1:0] acc;
    logic [CNT_W+1:0] acc_next;
    logic [CNT_W-1:0] hist [4];
    logic [2:0]       hist_cnt;

    // Running sum of the window: add the newest period, drop the oldest once 4 are held.
    always_comb begin
        acc_next = acc + {2'b00, counter};
        if (hist_cnt == 3'd4) begin
            acc_next = acc_next - {2'b00, hist[3]};
        end
    end

    assign new_result = capture && (hist_cnt >= 3'd3);
    assign result_val = CNT_W'(acc_next >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            hist_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
        end else if (stall) begin
            acc      <= '0;
            hist_cnt <= '0;
        end else if (capture) begin
            acc     <= acc_next;
            hist[0] <= counter;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            if (hist_cnt != 3'd4) begin
                hist_cnt <= hist_cnt + 3'd1;
            end
        end
    end
`else
    assign new_result = capture;
    assign result_val = counter;
`endif

    // A rise in the same cycle as the timeout threshold counts as a valid period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            counter              <= '0;
            timeout              <= 1'b0;
            overrun              <= 1'b0;
            result.period_o      <= '0;
            result.period_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        counter <= CNT_ONE;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        counter <= CNT_ONE;
                    end else if (stall) begin
                        timeout <= 1'b1;
                        state   <= STALE;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                STALE: begin
                    if (rise) begin
                        timeout <= 1'b0;
                        counter <= CNT_ONE;
                        state   <= MEASURE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase

            if (new_result) begin
                result.period_o     <= result_val;
                result.period_valid <= 1'b1;
                if (result.period_valid && !result.period_ready) begin
                    overrun <= 1'b1;
                end
            end else if (result.period_valid && result.period_ready) begin
                result.period_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: directed scenarios followed by randomized pulse trains,
// compared each cycle against a timestamp-based reference model.
module tb_pulse_meter;
    localparam int CLK_HZ      = 1000;
    localparam int MAX_PERIOD  = 100;
    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;

    typedef enum {M_IDLE, M_MEAS, M_STALE} model_mode_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic pulse_in = 1'b0;
    logic pulse_lvl;
    logic timeout;
    logic overrun;

    pulse_meter_if #(.CNT_W(CNT_W)) res_if ();

    pulse_meter #(
        .CLK_HZ     (CLK_HZ),
        .MAX_PERIOD (MAX_PERIOD),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .pulse_lvl(pulse_lvl),
        .result   (res_if),
        .timeout  (timeout),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int          tests       = 0;
    int          fails       = 0;
    int          edge_no     = 0;
    int          pend[$];
    int          hist[$];
    bit          prev_pin    = 1'b0;
    bit          s0          = 1'b0;
    bit          s1          = 1'b0;
    model_mode_t mode        = M_IDLE;
    int          last_rise   = 0;
    int          exp_period  = 0;
    bit          exp_valid   = 1'b0;
    bit          exp_timeout = 1'b0;
    bit          exp_overrun = 1'b0;

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Rises are tracked as edge timestamps; a period is the difference between two of them.
    task automatic modelEdge();
        bit rise;
        bit emit;
        int raw;
        int val;
        edge_no++;
        if (rst) begin
            s0 = 1'b0;
            s1 = 1'b0;
            prev_pin = 1'b0;
            pend.delete();
            hist.delete();
            mode = M_IDLE;
            exp_period = 0;
            exp_valid = 1'b0;
            exp_timeout = 1'b0;
            exp_overrun = 1'b0;
            return;
        end
        s1 = s0;
        s0 = pulse_in;
        if (pulse_in && !prev_pin) pend.push_back(edge_no + SYNC_STAGES);
        prev_pin = pulse_in;
        rise = 1'b0;
        if (pend.size() > 0 && pend[0] == edge_no) begin
            rise = 1'b1;
            void'(pend.pop_front());
        end
        emit = 1'b0;
        val = 0;
        if (rise) begin
            if (mode == M_MEAS) begin
                raw = edge_no - last_rise;
`ifdef PULSE_METER_AVG_EN
                hist.push_back(raw);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4) begin
                    emit = 1'b1;
                    val = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
                end
`else
                emit = 1'b1;
                val = raw;
`endif
            end
            mode = M_MEAS;
            exp_timeout = 1'b0;
            last_rise = edge_no;
        end else if (mode == M_MEAS && edge_no - last_rise >= MAX_PERIOD) begin
            exp_timeout = 1'b1;
            mode = M_STALE;
            hist.delete();
        end
        if (emit) begin
            if (exp_valid && !res_if.period_ready) exp_overrun = 1'b1;
            exp_period = val;
            exp_valid = 1'b1;
        end else if (exp_valid && res_if.period_ready) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic checkOutput();
        compare($sformatf("pulse_lvl@%0d", edge_no), pulse_lvl, s1);
        compare($sformatf("period_o@%0d", edge_no), res_if.period_o, exp_period);
        compare($sformatf("period_valid@%0d", edge_no), res_if.period_valid, exp_valid);
        compare($sformatf("timeout@%0d", edge_no), timeout, exp_timeout);
        compare($sformatf("overrun@%0d", edge_no), overrun, exp_overrun);
    endtask

    // rdy_mode: 0 hold ready low, 1 hold ready high, 2 random ready
    task automatic tick(input int rdy_mode);
        if (rdy_mode == 0) res_if.period_ready = 1'b0;
        else if (rdy_mode == 1) res_if.period_ready = 1'b1;
        else res_if.period_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input int high, input int low, input int reps, input int rdy_mode);
        for (int r = 0; r < reps; r++) begin
            pulse_in = 1'b1;
            for (int i = 0; i < high; i++) tick(rdy_mode);
            pulse_in = 1'b0;
            for (int i = 0; i < low; i++) tick(rdy_mode);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_edge;
        res_if.period_ready = 1'b0;
        rst = 1'b1;
        pulse_in = 1'b0;
        tick(0);
        tick(0);
        compare("reset_period_o", res_if.period_o, 0);
        compare("reset_valid", res_if.period_valid, 0);
        compare("reset_timeout", timeout, 0);
        compare("reset_overrun", overrun, 0);
        compare("reset_pulse_lvl", pulse_lvl, 0);
        rst = 1'b0;

        applyStimulus(10, 10, 5, 1);
        compare("t1_period", res_if.period_o, 20);
        compare("t1_timeout", timeout, 0);

        t_edge = -1;
        for (int i = 0; i < 110; i++) begin
            tick(1);
            if (timeout === 1'b1 && t_edge < 0) t_edge = edge_no;
        end
        compare("t2_timeout", timeout, 1);
        compare("t2_timeout_delay", 32'(t_edge - last_rise), 100);
        applyStimulus(10, 10, 3, 1);
        compare("t2_resume_timeout", timeout, 0);
        compare("t2_resume_period", res_if.period_o, 20);

        applyStimulus(10, 10, 3, 0);
        applyStimulus(15, 15, 1, 0);
        pulse_in = 1'b1;
        for (int i = 0; i < 4; i++) tick(0);
        compare("t3_valid", res_if.period_valid, 1);
        compare("t3_overrun", overrun, 1);
`ifdef PULSE_METER_AVG_EN
        compare("t3_period", res_if.period_o, 22);
`else
        compare("t3_period", res_if.period_o, 30);
`endif
        tick(1);
        compare("t3_valid_cleared", res_if.period_valid, 0);

        pulse_in = 1'b0;
        for (int i = 0; i < 5; i++) tick(1);
        doReset();
        compare("t4_period", res_if.period_o, 0);
        compare("t4_valid", res_if.period_valid, 0);
        compare("t4_timeout", timeout, 0);
        compare("t4_overrun", overrun, 0);
        compare("t4_pulse_lvl", pulse_lvl, 0);
        applyStimulus(10, 10, 1, 1);
        compare("t4_first_rise_period", res_if.period_o, 0);
        applyStimulus(10, 10, 1, 1);
`ifdef PULSE_METER_AVG_EN
        compare("t4_second_rise_period", res_if.period_o, 0);
`else
        compare("t4_second_rise_period", res_if.period_o, 20);
`endif

        applyStimulus(50, 50, 3, 0);
        compare("t5_valid", res_if.period_valid, 1);
        compare("t5_timeout", timeout, 0);
`ifdef PULSE_METER_AVG_EN
        compare("t5_period", res_if.period_o, 60);
`else
        compare("t5_period", res_if.period_o, 100);
`endif

`ifdef PULSE_METER_AVG_EN
        doReset();
        applyStimulus(10, 10, 2, 0);
        applyStimulus(12, 12, 2, 0);
        applyStimulus(14, 14, 1, 0);
        compare("t6_first_avg", res_if.period_o, 22);
        pulse_in = 1'b1;
        for (int i = 0; i < 4; i++) tick(0);
        compare("t6_second_avg", res_if.period_o, 24);
        pulse_in = 1'b0;
`endif

        doReset();
        for (int n = 0; n < 40; n++) begin
            if (n == 20) begin
                pulse_in = 1'b0;
                for (int i = 0; i < 3; i++) tick(2);
                doReset();
            end
            applyStimulus(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)), 1, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
